// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and defaults for the Pong reset sequencer.
//   seqState_t  : sequencer state encoding (ASSERT_ALL, WAIT_ACK, DONE)
//   DEF_*       : default parameter values for reset_sequencer
//   cntWidth()  : counter width helper, $clog2 with a floor of one bit
// ---------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT_ALL = 2'd0,
    WAIT_ACK   = 2'd1,
    DONE       = 2'd2
  } seqState_t;

  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_ACK_TIMEOUT = 255;

  // A terminal count of 1 would give $clog2 == 0, which is not a legal
  // vector width, so every counter keeps at least one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// ---------------------------------------------------------------------------
// rst_sync_2ff
// Two-flop reset synchronizer: asserts asynchronously with i_rstN, releases
// on the second rising i_clk edge after i_rstN goes high.
// Ports:
//   i_clk      : clock
//   i_rstN     : asynchronous active-low reset in
//   o_rstSyncN : active-low reset out, deassertion aligned to i_clk
// ---------------------------------------------------------------------------
module rst_sync_2ff (
  input  logic i_clk,
  input  logic i_rstN,
  output logic o_rstSyncN
);

  logic r_meta;
  logic r_sync;

  // Shift a constant one through two flops so the release edge is clean
  // even if i_rstN rises right next to a clock edge.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign o_rstSyncN = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Sequences the Pong subsystem resets (VGA timing, game logic, score display).
// All stages are held in reset for HOLD_CYCLES after the synchronized reset
// release, then released one by one in index order, each waiting for its
// ready acknowledge or a timeout before the next stage is released.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   sw_rst_req  : synchronous soft-reset request
//   stage_ack   : per-stage ready acknowledges
//   stage_rst   : per-stage active-high resets
//   all_ready   : every stage released, sequencing complete
//   seq_busy    : sequencer not in DONE
//   cur_stage   : index of the stage being released / waited on
//   timeout_err : sticky, some stage advanced by timeout
// Optional feature macro: RESET_SEQ_ACK_LOSS_EN
//   When defined, any stage ack low for two consecutive cycles in DONE
//   re-runs the whole sequence (timeout_err is preserved).
// ---------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sw_rst_req,
  input  logic [NUM_STAGES-1:0]           stage_ack,
  output logic [NUM_STAGES-1:0]           stage_rst,
  output logic                            all_ready,
  output logic                            seq_busy,
  output logic [cntWidth(NUM_STAGES)-1:0] cur_stage,
  output logic                            timeout_err
);

  localparam int SW = cntWidth(NUM_STAGES);
  localparam int HW = cntWidth(HOLD_CYCLES);
  localparam int TW = cntWidth(ACK_TIMEOUT);

  localparam logic [SW-1:0] LAST_IDX  = SW'(NUM_STAGES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

  logic            w_rstSyncN;
  logic [SW-1:0]   w_nextIdx;

  seqState_t       r_state;
  logic [HW-1:0]   r_holdCnt;
  logic [TW-1:0]   r_toCnt;
  logic [SW-1:0]   r_idx;
  logic [NUM_STAGES-1:0] r_stageRst;
  logic            r_allReady;
  logic            r_seqBusy;
  logic            r_timeoutErr;
`ifdef RESET_SEQ_ACK_LOSS_EN
  logic            r_lossSeen;
`endif

  rst_sync_2ff u_rstSync (
    .i_clk      (clk),
    .i_rstN     (rst),
    .o_rstSyncN (w_rstSyncN)
  );

  assign w_nextIdx = r_idx + 1'b1;

  // Sequencer FSM. The synchronized reset still asserts asynchronously, so
  // rst low forces the reset values without waiting for a clock. Soft reset
  // outranks every other transition, including a same-cycle ack or timeout.
  // Releasing a stage and moving to the next index happen on the same edge,
  // so a sampled ack releases the following stage with no extra latency.
  always_ff @(posedge clk or negedge w_rstSyncN) begin
    if (!w_rstSyncN) begin
      r_state      <= ASSERT_ALL;
      r_holdCnt    <= '0;
      r_toCnt      <= '0;
      r_idx        <= '0;
      r_stageRst   <= '1;
      r_allReady   <= 1'b0;
      r_seqBusy    <= 1'b1;
      r_timeoutErr <= 1'b0;
`ifdef RESET_SEQ_ACK_LOSS_EN
      r_lossSeen   <= 1'b0;
`endif
    end else if (sw_rst_req) begin
      r_state      <= ASSERT_ALL;
      r_holdCnt    <= '0;
      r_toCnt      <= '0;
      r_idx        <= '0;
      r_stageRst   <= '1;
      r_allReady   <= 1'b0;
      r_seqBusy    <= 1'b1;
      r_timeoutErr <= 1'b0;
`ifdef RESET_SEQ_ACK_LOSS_EN
      r_lossSeen   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ASSERT_ALL: begin
          if (r_holdCnt == HOLD_LAST) begin
            r_state       <= WAIT_ACK;
            r_holdCnt     <= '0;
            r_toCnt       <= '0;
            r_idx         <= '0;
            r_stageRst[0] <= 1'b0;
          end else begin
            r_holdCnt <= r_holdCnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (stage_ack[r_idx] || (r_toCnt == TO_LAST)) begin
            if (!stage_ack[r_idx]) begin
              r_timeoutErr <= 1'b1;
            end
            r_toCnt <= '0;
            if (r_idx == LAST_IDX) begin
              r_state    <= DONE;
              r_allReady <= 1'b1;
              r_seqBusy  <= 1'b0;
            end else begin
              r_idx                 <= w_nextIdx;
              r_stageRst[w_nextIdx] <= 1'b0;
            end
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        DONE: begin
`ifdef RESET_SEQ_ACK_LOSS_EN
          if (!(&stage_ack)) begin
            if (r_lossSeen) begin
              r_state    <= ASSERT_ALL;
              r_holdCnt  <= '0;
              r_toCnt    <= '0;
              r_idx      <= '0;
              r_stageRst <= '1;
              r_allReady <= 1'b0;
              r_seqBusy  <= 1'b1;
              r_lossSeen <= 1'b0;
            end else begin
              r_lossSeen <= 1'b1;
            end
          end else begin
            r_lossSeen <= 1'b0;
          end
`else
          r_state <= DONE;
`endif
        end
        default: begin
          r_state    <= ASSERT_ALL;
          r_holdCnt  <= '0;
          r_toCnt    <= '0;
          r_idx      <= '0;
          r_stageRst <= '1;
          r_allReady <= 1'b0;
          r_seqBusy  <= 1'b1;
        end
      endcase
    end
  end

  assign stage_rst   = r_stageRst;
  assign all_ready   = r_allReady;
  assign seq_busy    = r_seqBusy;
  assign cur_stage   = r_idx;
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer with NUM_STAGES=3, HOLD_CYCLES=4,
// ACK_TIMEOUT=8. Expected values are hand-computed edge by edge.
// Honours RESET_SEQ_ACK_LOSS_EN for the ack-loss scenario.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       sw_rst_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst;
  logic       all_ready;
  logic       seq_busy;
  logic [1:0] cur_stage;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  reset_sequencer #(
    .NUM_STAGES  (3),
    .HOLD_CYCLES (4),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw_rst_req),
    .stage_ack   (stage_ack),
    .stage_rst   (stage_rst),
    .all_ready   (all_ready),
    .seq_busy    (seq_busy),
    .cur_stage   (cur_stage),
    .timeout_err (timeout_err)
  );

  // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the synchronous inputs just after an edge.
  task automatic applyStimulus(input logic swReq, input logic [2:0] ack);
    sw_rst_req = swReq;
    stage_ack  = ack;
  endtask

  // Advance n rising edges, leaving time 1 unit past the last one.
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Directed scenario list; each block notes the edge it expects to see.
  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 3'b111);

    // Power-up reset values
    waitCycles(5);
    checkOutput("rst_stage_rst", stage_rst, 3'b111);
    checkOutput("rst_all_ready", all_ready, 1'b0);
    checkOutput("rst_seq_busy", seq_busy, 1'b1);
    checkOutput("rst_cur_stage", cur_stage, 2'd0);
    checkOutput("rst_timeout_err", timeout_err, 1'b0);

    // Release: 2 sync edges + 4 hold edges, then one stage per edge
    rst = 1'b1;
    waitCycles(5);
    checkOutput("pu_hold", stage_rst, 3'b111);
    checkOutput("pu_hold_busy", seq_busy, 1'b1);
    waitCycles(1);
    checkOutput("pu_rel0", stage_rst, 3'b110);
    checkOutput("pu_rel0_idx", cur_stage, 2'd0);
    waitCycles(1);
    checkOutput("pu_rel1", stage_rst, 3'b100);
    checkOutput("pu_rel1_idx", cur_stage, 2'd1);
    waitCycles(1);
    checkOutput("pu_rel2", stage_rst, 3'b000);
    checkOutput("pu_rel2_ready", all_ready, 1'b0);
    waitCycles(1);
    checkOutput("pu_done_ready", all_ready, 1'b1);
    checkOutput("pu_done_busy", seq_busy, 1'b0);
    checkOutput("pu_done_idx", cur_stage, 2'd2);
    checkOutput("pu_done_to", timeout_err, 1'b0);

    // Delayed ack on stage 1: sampled 3 edges after stage_rst[1] falls
    applyStimulus(1'b1, 3'b101);
    waitCycles(1);
    applyStimulus(1'b0, 3'b101);
    waitCycles(4);
    checkOutput("dly_rel0", stage_rst, 3'b110);
    waitCycles(1);
    checkOutput("dly_rel1", stage_rst, 3'b100);
    waitCycles(2);
    checkOutput("dly_wait", stage_rst, 3'b100);
    applyStimulus(1'b0, 3'b111);
    waitCycles(1);
    checkOutput("dly_rel2", stage_rst, 3'b000);
    checkOutput("dly_no_to", timeout_err, 1'b0);
    waitCycles(1);
    checkOutput("dly_done", all_ready, 1'b1);

    // Timeout on stage 0: stage 1 released 8 edges after stage 0
    applyStimulus(1'b1, 3'b110);
    waitCycles(1);
    applyStimulus(1'b0, 3'b110);
    waitCycles(4);
    checkOutput("to_rel0", stage_rst, 3'b110);
    waitCycles(7);
    checkOutput("to_wait", stage_rst, 3'b110);
    checkOutput("to_wait_err", timeout_err, 1'b0);
    waitCycles(1);
    checkOutput("to_rel1", stage_rst, 3'b100);
    checkOutput("to_err", timeout_err, 1'b1);
    checkOutput("to_idx", cur_stage, 2'd1);
    waitCycles(2);
    checkOutput("to_done", all_ready, 1'b1);
    checkOutput("to_err_sticky", timeout_err, 1'b1);

    // Soft reset pulse in DONE clears timeout_err and re-runs the hold
    applyStimulus(1'b1, 3'b111);
    waitCycles(1);
    applyStimulus(1'b0, 3'b111);
    checkOutput("sw_stage_rst", stage_rst, 3'b111);
    checkOutput("sw_all_ready", all_ready, 1'b0);
    checkOutput("sw_to_clr", timeout_err, 1'b0);
    waitCycles(3);
    checkOutput("sw_hold", stage_rst, 3'b111);
    waitCycles(1);
    checkOutput("sw_rel0", stage_rst, 3'b110);
    waitCycles(3);
    checkOutput("sw_done", all_ready, 1'b1);

    // Soft reset held high keeps hold_cnt at zero
    applyStimulus(1'b1, 3'b111);
    waitCycles(3);
    checkOutput("swh_held", stage_rst, 3'b111);
    applyStimulus(1'b0, 3'b111);
    waitCycles(3);
    checkOutput("swh_hold", stage_rst, 3'b111);
    waitCycles(1);
    checkOutput("swh_rel0", stage_rst, 3'b110);
    waitCycles(3);
    checkOutput("swh_done", all_ready, 1'b1);

    // Soft reset in the same cycle as stage 2 ack: soft reset wins
    applyStimulus(1'b1, 3'b011);
    waitCycles(1);
    applyStimulus(1'b0, 3'b011);
    waitCycles(6);
    checkOutput("cf_wait2", stage_rst, 3'b000);
    checkOutput("cf_wait2_idx", cur_stage, 2'd2);
    applyStimulus(1'b1, 3'b111);
    waitCycles(1);
    applyStimulus(1'b0, 3'b111);
    checkOutput("cf_stage_rst", stage_rst, 3'b111);
    checkOutput("cf_all_ready", all_ready, 1'b0);
    checkOutput("cf_busy", seq_busy, 1'b1);
    waitCycles(7);
    checkOutput("cf_done", all_ready, 1'b1);

    // Asynchronous rst in WAIT_ACK: reset values without a clock edge
    applyStimulus(1'b1, 3'b000);
    waitCycles(1);
    applyStimulus(1'b0, 3'b000);
    waitCycles(6);
    checkOutput("ar_waiting", stage_rst, 3'b110);
    rst = 1'b0;
    #1;
    checkOutput("ar_stage_rst", stage_rst, 3'b111);
    checkOutput("ar_busy", seq_busy, 1'b1);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 3'b111);
    waitCycles(5);
    checkOutput("ar_hold", stage_rst, 3'b111);
    waitCycles(1);
    checkOutput("ar_rel0", stage_rst, 3'b110);
    waitCycles(3);
    checkOutput("ar_done", all_ready, 1'b1);

    // Ack loss in DONE: a 1-cycle drop never matters
    applyStimulus(1'b0, 3'b101);
    waitCycles(1);
    applyStimulus(1'b0, 3'b111);
    waitCycles(1);
    checkOutput("al1_ready", all_ready, 1'b1);
    checkOutput("al1_stage_rst", stage_rst, 3'b000);

    // Ack loss in DONE: a 2-cycle drop re-sequences only with the feature
    applyStimulus(1'b0, 3'b101);
    waitCycles(2);
    applyStimulus(1'b0, 3'b111);
`ifdef RESET_SEQ_ACK_LOSS_EN
    checkOutput("al2_stage_rst", stage_rst, 3'b111);
    checkOutput("al2_ready", all_ready, 1'b0);
    waitCycles(3);
    checkOutput("al2_hold", stage_rst, 3'b111);
    waitCycles(1);
    checkOutput("al2_rel0", stage_rst, 3'b110);
    waitCycles(3);
    checkOutput("al2_done", all_ready, 1'b1);
`else
    checkOutput("al2_ready", all_ready, 1'b1);
    checkOutput("al2_stage_rst", stage_rst, 3'b000);
    waitCycles(3);
    checkOutput("al2_still_ready", all_ready, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
